// File: rtl/uart_pkg.sv
// Shared UART types: framer state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Round-to-nearest clocks per line bit.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO; a push while full is dropped even if a pop happens the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; back-to-back frames when data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       ld_tx_data,
  input  logic       tx_enable,
  output logic       tx_empty,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       overflow,
  output logic       tx_out
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);

  tx_state_t     state, state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_byte;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count, count_nxt;
  logic          pop, push_ok, baud_done, can_start;
  logic          tx_out_nxt;

  byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ld_tx_data),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_done = (baud_cnt == BW'(DIV - 1));
  assign push_ok   = ld_tx_data && !fifo_full;
  assign can_start = !fifo_empty && tx_enable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_byte  <= '0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_out   <= tx_out_nxt;
      tx_busy  <= (state_nxt != IDLE);
      tx_full  <= (count_nxt == (AW+1)'(DEPTH));
      tx_empty <= (count_nxt == '0) && (state_nxt == IDLE);
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      if (state == START)                 bit_cnt <= '0;
      else if (state == DATA && baud_done) bit_cnt <= bit_cnt + 1'b1;
      if (pop)                        tx_byte  <= fifo_dout;
      if (ld_tx_data && fifo_full)    overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (can_start) begin state_nxt = START; pop = 1'b1; end
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:  if (baud_done) begin
               if (can_start) begin state_nxt = START; pop = 1'b1; end
               else           state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Line value for the cycle after this edge; bit_cnt indexes tx_byte directly, no shifting.
  always_comb begin
    tx_out_nxt = tx_out;
    count_nxt  = fifo_count;
    case ({push_ok, pop})
      2'b10:   count_nxt = fifo_count + 1'b1;
      2'b01:   count_nxt = fifo_count - 1'b1;
      default: count_nxt = fifo_count;
    endcase
    if (pop) tx_out_nxt = 1'b0;
    else begin
      case (state)
        IDLE:  tx_out_nxt = 1'b1;
        START: if (baud_done) tx_out_nxt = tx_byte[0];
        DATA:  if (baud_done) tx_out_nxt = (bit_cnt == 3'd7) ? 1'b1 : tx_byte[bit_cnt + 3'd1];
        STOP:  if (baud_done) tx_out_nxt = 1'b1;
        default: tx_out_nxt = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized + directed bench: frame-level reference model feeding a byte scoreboard and per-cycle flag check.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;
  localparam int DEPTH = 8;

  logic       clk, rst_n, ld_tx_data, tx_enable;
  logic [7:0] tx_data;
  logic       tx_empty, tx_full, tx_busy, overflow, tx_out;

  uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .ld_tx_data (ld_tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty),
    .tx_full    (tx_full),
    .tx_busy    (tx_busy),
    .overflow   (overflow),
    .tx_out     (tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of bytes plus position inside the current 10*DIV-cycle frame.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_busy = 0, m_ovf = 0, chk_en = 0;
  int         m_pos  = 0;
  logic [7:0] m_byte = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete(); exp_q.delete();
        m_busy = 0; m_pos = 0; m_ovf = 0; chk_en = 1;
      end else begin
        int  pre;
        bit  fend, popn, acc;
        pre  = mq.size();
        fend = m_busy && (m_pos == FRAME - 1);
        popn = (!m_busy || fend) && pre > 0 && tx_enable;
        acc  = pre < DEPTH;
        if (popn) begin
          m_byte = mq.pop_front();
          exp_q.push_back(m_byte);
          m_busy = 1; m_pos = 0;
        end else if (fend) m_busy = 0;
        else if (m_busy)   m_pos++;
        if (ld_tx_data) begin
          if (acc) mq.push_back(tx_data);
          else     m_ovf = 1;
        end
      end
    end
  end

  function automatic logic exp_line();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_pos / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  // Per-cycle flag/line check and line-decoding scoreboard monitor.
  bit         mon_act = 0, mon_prev = 1;
  int         mon_t = 0;
  logic [7:0] mon_byte = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic [8:0] act, exp;
        act = {tx_out, tx_busy, tx_full, tx_empty, overflow, dut.u_fifo.count};
        exp = {exp_line(), m_busy, mq.size() == DEPTH, (mq.size() == 0) && !m_busy, m_ovf, 4'(mq.size())};
        check("cycle_state", 32'(act), 32'(exp));

        if (mon_act && !m_busy) mon_act = 0;
        if (!mon_act) begin
          if (mon_prev && !tx_out) begin mon_act = 1; mon_t = 0; mon_byte = '0; end
        end else mon_t++;
        if (mon_act && (mon_t % DIV) == DIV / 2) begin
          int idx;
          idx = mon_t / DIV;
          if (idx == 0)      check("start_bit", 32'(tx_out), 32'd0);
          else if (idx <= 8) mon_byte[idx-1] = tx_out;
          else begin
            check("stop_bit", 32'(tx_out), 32'd1);
            if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(mon_byte), 32'h100);
            else                   check("sb_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
            mon_act = 0;
          end
        end
        mon_prev = tx_out;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [7:0] d);
    ld_tx_data = 1'b1; tx_data = d;
    tick(1);
    ld_tx_data = 1'b0;
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; ld_tx_data = 1'b0; tx_enable = 1'b1; tx_data = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // single byte while idle
    push(8'hA5);
    tick(110);

    // fill with no pop, then a dropped push, then contiguous drain
    tx_enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    push(8'hFF);
    tick(2);
    tx_enable = 1'b1;
    tick(850);

    // enable drops during the 3rd data bit with two bytes queued
    push(8'h3C); push(8'hC3); push(8'h5A);
    tick(32);
    tx_enable = 1'b0;
    tick(200);
    tx_enable = 1'b1;
    tick(250);

    // reset mid-DATA
    push(8'h96); push(8'h69);
    tick(40);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // push coinciding with the STOP->START pop at count 1
    push(8'h11); push(8'h22);
    done = 0;
    for (int i = 0; i < 2 * FRAME && !done; i++) begin
      if (m_busy && m_pos == FRAME - 1) done = 1;
      else tick(1);
    end
    if (!done) check("sync_push_timeout", 32'd0, 32'd1);
    push(8'h33);
    check("sync_push_count", 32'(dut.u_fifo.count), 32'd1);
    tick(2 * FRAME + 20);

    // randomized traffic with occasional enable toggles and resets
    for (int i = 0; i < 3000; i++) begin
      ld_tx_data = ($urandom_range(0, 11) == 0);
      tx_data    = 8'($urandom);
      if ($urandom_range(0, 199) == 0) tx_enable = ~tx_enable;
      rst_n      = ($urandom_range(0, 999) != 0);
      tick(1);
    end
    rst_n = 1'b1; ld_tx_data = 1'b0; tx_enable = 1'b1;

    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (mq.size() == 0 && !m_busy) done = 1;
      else tick(1);
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    tick(10);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 8, meaning byte FIFO depth; a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port tx_data, input, 8 bits: byte to transmit.
REQ-007 SHALL have port ld_tx_data, input, 1 bit: push tx_data into the FIFO this cycle.
REQ-008 SHALL have port tx_enable, input, 1 bit: permits new frames to start.
REQ-009 SHALL have port tx_empty, output, 1 bit: FIFO empty and shifter idle.
REQ-010 SHALL have port tx_full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-011 SHALL have port tx_busy, output, 1 bit: a frame is on the line.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.
REQ-013 SHALL have port tx_out, output, 1 bit: serial line, idle high.

Function
REQ-014 SHALL compute DIV = (CLK_HZ + BAUD/2) / BAUD; every line bit SHALL last exactly DIV clk cycles.
REQ-015 SHALL frame each byte as 8N1: one start bit (0), data bits LSB first, one stop bit (1); a frame is 10*DIV cycles.
REQ-016 SHALL write tx_data into the FIFO at the edge where ld_tx_data=1 and tx_full=0.
REQ-017 SHALL drop a push made while tx_full=1, even if a pop occurs in the same cycle, and set overflow; overflow stays set until reset.
REQ-018 SHALL, on a simultaneous accepted push and pop, leave the occupancy count unchanged and preserve FIFO order.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH; the count SHALL range over 0..DEPTH.
REQ-020 SHALL implement states IDLE, START, DATA, STOP.
REQ-021 SHALL, in IDLE with count>0 and tx_enable=1, pop the head byte into the shift register and enter START; tx_out SHALL be registered 0 from that edge.
REQ-022 SHALL latency: a byte pushed into an empty FIFO while IDLE with tx_enable=1 drives tx_out low one cycle after the push edge.
REQ-023 SHALL move START to DATA after DIV cycles, DATA to STOP after 8*DIV cycles, and STOP onward after DIV cycles.
REQ-024 SHALL leave STOP for START directly, popping with no idle gap, if count>0 and tx_enable=1; otherwise it SHALL go to IDLE.
REQ-025 SHALL, when tx_enable is deasserted mid-frame, complete the current frame; it SHALL start no new frame while tx_enable=0.
REQ-026 SHALL drive tx_busy=1 in START, DATA and STOP.
REQ-027 SHALL drive tx_empty = (count==0) and (state==IDLE), and tx_full = (count==DEPTH).
REQ-028 SHALL register all outputs; tx_out SHALL be glitch-free.

Reset
REQ-029 SHALL, with rst_n=0 at an edge, force state IDLE, tx_out=1, count=0, both pointers 0, overflow=0, tx_busy=0, tx_full=0, tx_empty=1, and clear the baud and bit counters.
REQ-030 SHALL, on a reset asserted mid-frame, return tx_out to 1 from the next edge; the in-flight byte and all FIFO contents SHALL be discarded.

Structure
REQ-031 SHALL place the state enumeration and the DIV computation function in shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module, byte_fifo, a synchronous FIFO with push, pop, full, empty and count; the framer/baud logic SHALL stay in uart_tx_fifo.

Verification (CLK_HZ=1000, BAUD=100, so DIV=10)
REQ-033 SHALL cover: single push of 0xA5 while idle -> tx_out low 1 cycle later, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop bit high, tx_empty=1 after 100 cycles.
REQ-034 SHALL cover: 8 pushes of 0x00..0x07 back-to-back -> tx_full=1 after the 8th push with no pop yet, 8 contiguous frames totalling 800 cycles with no idle gap, bytes in order.
REQ-035 SHALL cover: a 9th push of 0xFF while full -> byte absent from the line and overflow=1 until reset.
REQ-036 SHALL cover: tx_enable=0 during the 3rd data bit with 2 bytes queued -> current frame completes, tx_out stays 1, next frame starts 1 cycle after tx_enable returns high.
REQ-037 SHALL cover: rst_n=0 for 1 cycle during DATA -> tx_out=1 next cycle, tx_empty=1, count=0, overflow=0.
REQ-038 SHALL cover: push coinciding with the STOP-to-START pop at count=1 -> count stays 1 and the pushed byte is sent next.
